axi_mem_responder: RTL and testbench
====================================

Name: axi_mem_responder

Overview:
- AXI4 slave (responder) backed by on-chip block RAM, 128-bit data path.
- Stands in for the MIG AXI slave port in simulation and small-memory builds. It lets the DRAM front-end's AXI master drive s_axi_* into on-chip storage instead of DDR.
- Read and write channels run independent state machines that share one dual-port memory array.

Parameters:
ADDR_WIDTH, 28, AXI byte address width
DATA_WIDTH, 128, data bus width (fixed at 128; beat = 16 bytes)
STRB_WIDTH, 16, write strobe width (DATA_WIDTH/8)
ID_WIDTH, 4, AXI ID width
MEM_WORDS_LOG2, 10, log2 of memory depth in 128-bit words

Ports:
i_clk  in  1  clock for all logic
i_rst  in  1  synchronous, active-high reset
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awaddr  in  ADDR_WIDTH  write byte address
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  ignored (beats always 16 B)
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  STRB_WIDTH  byte enables, bit n -> byte n
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  ID_WIDTH  response ID
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  ID_WIDTH  read ID
s_axi_araddr  in  ADDR_WIDTH  read byte address
s_axi_arlen  in  8  beats-1
s_axi_arsize  in  3  ignored
s_axi_arburst  in  2  as awburst
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  read ID
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is synchronous and active-high.
- Reset: both FSMs go to IDLE. All outputs read 0 while i_rst=1 (readies, valids, resp, last, id, rdata). Memory contents are not cleared.
- Addressing: word index = addr[MEM_WORDS_LOG2+3:4]. Higher address bits are ignored (aliasing). The index wraps modulo 2^MEM_WORDS_LOG2. addr[3:0] is ignored.
- Burst address update: INCR adds 1 to the index per beat. FIXED holds the index. WRAP (and 11) returns SLVERR: no memory writes; rdata=0 on every beat with the full beat count.
- Write FSM, W_IDLE:
  - awready=1.
  - On AW handshake, latch id, index, len, burst and error flag; go to W_DATA.
- Write FSM, W_DATA:
  - wready=1.
  - Each W handshake writes the strobed bytes of wdata into mem[index], then advances the index. Bytes with strobe 0 are unchanged.
  - Beat counter counts up from 0.
  - Burst ends on wlast=1 or when count==len. Go to W_RESP.
  - bresp=SLVERR if wlast is early (count<len) or missing on beat len. Otherwise OKAY, unless the latched error flag is set.
- Write FSM, W_RESP:
  - bvalid=1 and bid=latched id.
  - bvalid is held with stable bid/bresp until bready; the handshake returns to W_IDLE.
  - awready=0 throughout W_DATA and W_RESP.
- Read FSM, R_IDLE:
  - arready=1.
  - On AR handshake, latch id, index, len, burst and error flag; go to R_FETCH.
- Read FSM, R_FETCH: issue a synchronous memory read; go to R_DATA the next cycle.
- Read FSM, R_DATA:
  - rvalid=1, with rdata registered and rlast=(count==len).
  - rdata/rresp/rlast/rid are held stable while rvalid && !rready.
  - On handshake: if rlast, go to R_IDLE; else advance the index and go to R_FETCH.
- Read timing:
  - Latency from AR handshake to first rvalid is 2 cycles.
  - Sustained throughput is 1 beat per 2 cycles with rready tied high.
- Simultaneous read and write: a read and a write to the same word in the same cycle return the old data (read-first). The channels never stall each other.
- Reset mid-burst: the transaction is aborted with no B or R issued. Already-written beats persist.
- Max burst is len=255 (256 beats); the beat counter is 8 bits.

Test Plan:
- Single write, then single read: AW addr 0x40, len 0, INCR, wdata 0x00112233_44556677_8899AABB_CCDDEEFF, wstrb 0xFFFF, awid 3 -> bresp 00, bid 3. AR addr 0x40, arid 5 -> rdata equals written data, rlast 1, rid 5, rvalid 2 cycles after AR handshake.
- INCR 4-beat write at 0x100 with wstrb 0x000F on beat 2 -> read back 4 beats. Beat 2 has only bytes 0-3 updated; the other beats match; rlast only on beat 4.
- Read backpressure: 4-beat read, rready low for 5 cycles during beat 2 -> rvalid held and rdata stable. Exactly 4 beats delivered, no loss or duplication.
- FIXED write of 3 beats (A, B, C) to 0x200 -> the readback word is C. Bursts of type WRAP return bresp 10 and rresp 10 with rdata 0, and memory is unchanged.
- Write with wlast on beat 2 of awlen=3 -> burst ends, bresp 10, beats 1-2 written, awready reasserts after the B handshake.
- Reset asserted in R_DATA of an 8-beat read -> rvalid 0 the next cycle, arready 1 after reset release, and a new read returns correct data.

Source files
------------

// File: rtl/axi_mem_responder.sv
// axi_mem_responder
//   AXI4 slave backed by an on-chip 128-bit-wide memory array. It replaces the
//   DRAM controller's AXI port in simulation and in small-memory builds.
//   Independent write (AW/W/B) and read (AR/R) state machines share one
//   dual-port array: the write side owns the write port, the read side owns
//   the registered read port.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   s_axi_aw*               write address channel (size ignored, 16 B beats)
//   s_axi_w*                write data channel, wstrb bit n enables byte n
//   s_axi_b*                write response (OKAY / SLVERR)
//   s_axi_ar*               read address channel
//   s_axi_r*                read data channel
//
// Word index = addr[MEM_WORDS_LOG2+3:4]; upper bits alias, low nibble ignored.
// Bursts: FIXED holds the index, INCR adds one per beat, WRAP/reserved return
// SLVERR with no memory writes and all-zero read data.

module axi_mem_responder #(
    parameter int ADDR_WIDTH     = 28,
    parameter int DATA_WIDTH     = 128,
    parameter int STRB_WIDTH     = 16,
    parameter int ID_WIDTH       = 4,
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);
    localparam int         MEM_WORDS   = 1 << MEM_WORDS_LOG2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // ---------------------------------------------------------------- write
    w_state_t                  w_state_q;
    logic [ID_WIDTH-1:0]       w_id_q;
    logic [MEM_WORDS_LOG2-1:0] w_idx_q, w_idx_d;
    logic [7:0]                w_len_q, w_cnt_q;
    logic                      w_fixed_q, w_err_q;
    logic [1:0]                bresp_q;
    logic                      w_at_len;
    logic                      wr_en;
    logic [STRB_WIDTH-1:0]     wr_be;

    assign w_at_len = (w_cnt_q == w_len_q);
    assign w_idx_d  = w_fixed_q ? w_idx_q : w_idx_q + MEM_WORDS_LOG2'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_fixed_q <= 1'b0;
            w_err_q   <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (s_axi_awvalid) begin
                        w_id_q    <= s_axi_awid;
                        w_idx_q   <= s_axi_awaddr[MEM_WORDS_LOG2+3:4];
                        w_len_q   <= s_axi_awlen;
                        w_cnt_q   <= '0;
                        w_fixed_q <= (s_axi_awburst == BURST_FIXED);
                        w_err_q   <= s_axi_awburst[1];
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid) begin
                        if (s_axi_wlast || w_at_len) begin
                            // wlast must coincide exactly with beat len
                            bresp_q   <= (w_err_q || (s_axi_wlast != w_at_len))
                                         ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end else begin
                            w_cnt_q <= w_cnt_q + 8'd1;
                            w_idx_q <= w_idx_d;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Reset masks the write port so a burst cut by reset stops cleanly.
    assign wr_en = (w_state_q == W_DATA) && s_axi_wvalid && !w_err_q && !i_rst;

    generate
        for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_be
            assign wr_be[gi] = wr_en && s_axi_wstrb[gi];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wr_be[b]) begin
                mem[w_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    assign s_axi_awready = (w_state_q == W_IDLE) && !i_rst;
    assign s_axi_wready  = (w_state_q == W_DATA) && !i_rst;
    assign s_axi_bvalid  = (w_state_q == W_RESP) && !i_rst;
    assign s_axi_bid     = i_rst ? '0 : w_id_q;
    assign s_axi_bresp   = i_rst ? RESP_OKAY : bresp_q;

    // ----------------------------------------------------------------- read
    r_state_t                  r_state_q;
    logic [ID_WIDTH-1:0]       r_id_q;
    logic [MEM_WORDS_LOG2-1:0] r_idx_q, r_idx_d;
    logic [7:0]                r_len_q, r_cnt_q;
    logic                      r_fixed_q, r_err_q;
    logic [DATA_WIDTH-1:0]     rd_word_q;
    logic                      r_at_len;

    assign r_at_len = (r_cnt_q == r_len_q);
    assign r_idx_d  = r_fixed_q ? r_idx_q : r_idx_q + MEM_WORDS_LOG2'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_fixed_q <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        r_id_q    <= s_axi_arid;
                        r_idx_q   <= s_axi_araddr[MEM_WORDS_LOG2+3:4];
                        r_len_q   <= s_axi_arlen;
                        r_cnt_q   <= '0;
                        r_fixed_q <= (s_axi_arburst == BURST_FIXED);
                        r_err_q   <= s_axi_arburst[1];
                        r_state_q <= R_FETCH;
                    end
                end
                R_FETCH: r_state_q <= R_DATA;
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (r_at_len) begin
                            r_state_q <= R_IDLE;
                        end else begin
                            r_cnt_q   <= r_cnt_q + 8'd1;
                            r_idx_q   <= r_idx_d;
                            r_state_q <= R_FETCH;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Registered read, loaded only in R_FETCH so rdata stays put under
    // backpressure. A same-cycle write to this word lands after the read
    // (read-first).
    always_ff @(posedge i_clk) begin
        if (r_state_q == R_FETCH) begin
            rd_word_q <= mem[r_idx_q];
        end
    end

    assign s_axi_arready = (r_state_q == R_IDLE) && !i_rst;
    assign s_axi_rvalid  = (r_state_q == R_DATA) && !i_rst;
    assign s_axi_rlast   = s_axi_rvalid && r_at_len;
    assign s_axi_rid     = i_rst ? '0 : r_id_q;
    assign s_axi_rresp   = (i_rst || !r_err_q) ? RESP_OKAY : RESP_SLVERR;
    assign s_axi_rdata   = (s_axi_rvalid && !r_err_q) ? rd_word_q : '0;

    // Size fields and address bits outside the word index carry no meaning.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awsize, s_axi_arsize,
                             s_axi_awaddr[3:0], s_axi_araddr[3:0],
                             s_axi_awaddr[ADDR_WIDTH-1:MEM_WORDS_LOG2+4],
                             s_axi_araddr[ADDR_WIDTH-1:MEM_WORDS_LOG2+4]};

endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   awid, bid, arid, rid;
    logic [27:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic [127:0] wdata, rdata;
    logic [15:0]  wstrb;

    always #5 clk = ~clk;

    axi_mem_responder #(
        .ADDR_WIDTH(28), .DATA_WIDTH(128), .STRB_WIDTH(16),
        .ID_WIDTH(4), .MEM_WORDS_LOG2(10)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    int checks   = 0;
    int failures = 0;

    logic [127:0] wbeat  [8];
    logic [15:0]  wstrbv [8];
    logic [127:0] rdat   [16];
    logic [1:0]   rrsp   [16];
    logic         rlst   [16];
    logic [3:0]   rids   [16];
    int           rcount, rlat;
    logic [1:0]   bresp_got;
    logic [3:0]   bid_got;
    logic [127:0] exp_stall;

    localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    function automatic logic [127:0] pat(input logic [31:0] base, input int k);
        logic [31:0] w;
        w = base + 32'(k);
        return {w, w, w, w};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // lastb: beat index carrying wlast (-1 for none)
    task automatic do_write(input logic [3:0] id, input logic [27:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int nbeats, input int lastb);
        int n;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd4; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin step(); n++; end
        check("aw_ready", awready, 1'b1);
        step();
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            wdata = wbeat[b]; wstrb = wstrbv[b]; wlast = (b == lastb); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin step(); n++; end
            check("w_ready", wready, 1'b1);
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin step(); n++; end
        check("b_valid", bvalid, 1'b1);
        bresp_got = bresp; bid_got = bid;
        step();
        bready = 1'b0;
        $display("write id=%0d addr=%h len=%0d burst=%0d beats=%0d -> bresp=%0d bid=%0d",
                 id, addr, len, burst, nbeats, bresp_got, bid_got);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [27:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int stall_beat, input int stall_cycles);
        int  n;
        logic last;
        rready = 1'b1;
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd4; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin step(); n++; end
        check("ar_ready", arready, 1'b1);
        step();
        arvalid = 1'b0;
        rlat = 1;
        while (!rvalid && rlat < 20) begin step(); rlat++; end
        rcount = 0;
        n = 0;
        while (rcount < 16 && n < 200) begin
            if (rvalid) begin
                if (rcount == stall_beat) begin
                    rready = 1'b0;
                    for (int k = 0; k < stall_cycles; k++) begin
                        step();
                        check("stall_rvalid", rvalid, 1'b1);
                        check("stall_rdata", rdata, exp_stall);
                    end
                    rready = 1'b1;
                end
                rdat[rcount] = rdata; rrsp[rcount] = rresp;
                rlst[rcount] = rlast; rids[rcount] = rid;
                last = rlast;
                rcount++;
                step();
                if (last) break;
            end else begin
                step();
                n++;
            end
        end
        repeat (3) step();
        check("no_extra_beat", rvalid, 1'b0);
        $display("read id=%0d addr=%h len=%0d burst=%0d -> beats=%0d latency=%0d",
                 id, addr, len, burst, rcount, rlat);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b1;
        exp_stall = '0;
        repeat (3) step();
        check("rst_awready", awready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 128'h0);
        rst = 1'b0;
        step();
        check("idle_awready", awready, 1'b1);
        check("idle_arready", arready, 1'b1);

        // single write / single read
        wbeat[0] = D1; wstrbv[0] = 16'hFFFF;
        do_write(4'd3, 28'h40, 8'd0, 2'b01, 1, 0);
        check("t1_bresp", bresp_got, 2'b00);
        check("t1_bid", bid_got, 4'd3);
        do_read(4'd5, 28'h40, 8'd0, 2'b01, -1, 0);
        check("t1_beats", rcount, 1);
        check("t1_rdata", rdat[0], D1);
        check("t1_rlast", rlst[0], 1'b1);
        check("t1_rid", rids[0], 4'd5);
        check("t1_rresp", rrsp[0], 2'b00);
        check("t1_latency", rlat, 2);

        // INCR 4 beats, partial strobe on beat 2, read with backpressure on beat 2
        for (int k = 0; k < 4; k++) begin wbeat[k] = pat(32'hA000_0000, k); wstrbv[k] = 16'hFFFF; end
        do_write(4'd1, 28'h100, 8'd3, 2'b01, 4, 3);
        check("t2_pre_bresp", bresp_got, 2'b00);
        for (int k = 0; k < 4; k++) begin wbeat[k] = pat(32'hB000_0000, k); wstrbv[k] = 16'hFFFF; end
        wstrbv[1] = 16'h000F;
        do_write(4'd2, 28'h100, 8'd3, 2'b01, 4, 3);
        check("t2_bresp", bresp_got, 2'b00);
        exp_stall = {32'hA000_0001, 32'hA000_0001, 32'hA000_0001, 32'hB000_0001};
        do_read(4'd7, 28'h100, 8'd3, 2'b01, 1, 5);
        check("t2_beats", rcount, 4);
        check("t2_rdata0", rdat[0], pat(32'hB000_0000, 0));
        check("t2_rdata1", rdat[1], 128'hA0000001_A0000001_A0000001_B0000001);
        check("t2_rdata2", rdat[2], pat(32'hB000_0000, 2));
        check("t2_rdata3", rdat[3], pat(32'hB000_0000, 3));
        check("t2_rlast0", rlst[0], 1'b0);
        check("t2_rlast1", rlst[1], 1'b0);
        check("t2_rlast2", rlst[2], 1'b0);
        check("t2_rlast3", rlst[3], 1'b1);

        // FIXED burst keeps the last beat
        for (int k = 0; k < 3; k++) begin wbeat[k] = pat(32'hC000_0000, k); wstrbv[k] = 16'hFFFF; end
        do_write(4'd4, 28'h200, 8'd2, 2'b00, 3, 2);
        check("t4_fixed_bresp", bresp_got, 2'b00);
        do_read(4'd4, 28'h200, 8'd0, 2'b01, -1, 0);
        check("t4_fixed_rdata", rdat[0], pat(32'hC000_0000, 2));

        // WRAP write: SLVERR, memory untouched
        for (int k = 0; k < 2; k++) begin wbeat[k] = pat(32'hDEAD_0000, k); wstrbv[k] = 16'hFFFF; end
        do_write(4'd6, 28'h40, 8'd1, 2'b10, 2, 1);
        check("t4_wrap_bresp", bresp_got, 2'b10);
        do_read(4'd6, 28'h40, 8'd0, 2'b01, -1, 0);
        check("t4_wrap_mem", rdat[0], D1);
        // WRAP read: SLVERR, zero data, full beat count
        do_read(4'd8, 28'h100, 8'd1, 2'b10, -1, 0);
        check("t4_wrap_beats", rcount, 2);
        check("t4_wrap_rdata0", rdat[0], 128'h0);
        check("t4_wrap_rdata1", rdat[1], 128'h0);
        check("t4_wrap_rresp0", rrsp[0], 2'b10);
        check("t4_wrap_rresp1", rrsp[1], 2'b10);
        check("t4_wrap_rlast1", rlst[1], 1'b1);

        // early wlast
        for (int k = 0; k < 4; k++) begin wbeat[k] = pat(32'hE000_0000, k); wstrbv[k] = 16'hFFFF; end
        do_write(4'd2, 28'h300, 8'd3, 2'b01, 4, 3);
        check("t5_pre_bresp", bresp_got, 2'b00);
        for (int k = 0; k < 2; k++) begin wbeat[k] = pat(32'hF000_0000, k); wstrbv[k] = 16'hFFFF; end
        do_write(4'd9, 28'h300, 8'd3, 2'b01, 2, 1);
        check("t5_early_bresp", bresp_got, 2'b10);
        check("t5_early_bid", bid_got, 4'd9);
        check("t5_awready_after_b", awready, 1'b1);
        do_read(4'd1, 28'h300, 8'd3, 2'b01, -1, 0);
        check("t5_beats", rcount, 4);
        check("t5_rdata0", rdat[0], pat(32'hF000_0000, 0));
        check("t5_rdata1", rdat[1], pat(32'hF000_0000, 1));
        check("t5_rdata2", rdat[2], pat(32'hE000_0000, 2));
        check("t5_rdata3", rdat[3], pat(32'hE000_0000, 3));

        // missing wlast on beat len
        for (int k = 0; k < 2; k++) begin wbeat[k] = pat(32'h1234_0000, k); wstrbv[k] = 16'hFFFF; end
        do_write(4'd10, 28'h380, 8'd1, 2'b01, 2, -1);
        check("t5_nolast_bresp", bresp_got, 2'b10);
        do_read(4'd2, 28'h380, 8'd1, 2'b01, -1, 0);
        check("t5_nolast_rdata1", rdat[1], pat(32'h1234_0000, 1));

        // reset during R_DATA of an 8-beat read
        for (int k = 0; k < 8; k++) begin wbeat[k] = pat(32'h9000_0000, k); wstrbv[k] = 16'hFFFF; end
        do_write(4'd11, 28'h400, 8'd7, 2'b01, 8, 7);
        check("t6_bresp", bresp_got, 2'b00);
        rready = 1'b0;
        arid = 4'd12; araddr = 28'h400; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin step(); n++; end
        check("t6_ar_ready", arready, 1'b1);
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin step(); n++; end
        check("t6_pre_rvalid", rvalid, 1'b1);
        check("t6_pre_rdata", rdata, pat(32'h9000_0000, 0));
        rst = 1'b1;
        step();
        check("t6_rst_rvalid", rvalid, 1'b0);
        check("t6_rst_arready", arready, 1'b0);
        step();
        rst = 1'b0;
        rready = 1'b1;
        #1;
        check("t6_post_arready", arready, 1'b1);
        check("t6_post_rvalid", rvalid, 1'b0);
        $display("reset applied during 8-beat read, rvalid=%0d arready=%0d", rvalid, arready);
        do_read(4'd13, 28'h400, 8'd7, 2'b01, -1, 0);
        check("t6_beats", rcount, 8);
        check("t6_rdata0", rdat[0], pat(32'h9000_0000, 0));
        check("t6_rdata7", rdat[7], pat(32'h9000_0000, 7));
        check("t6_rlast7", rlst[7], 1'b1);
        check("t6_rid", rids[3], 4'd13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
